// File: rtl/fft_bitrev_buf.sv
// fft_bitrev_buf: ping-pong bit-reversal reorder buffer for the 64-point FFT output.
// One bank captures the incoming natural-order frame while the other bank is
// replayed in bit-reversed order. The output is a gap-free stream with a
// start-of-frame pulse.
module fft_bitrev_buf #(
  parameter int nb = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ED,
  input  logic                 START,
  input  logic signed [nb-1:0] DR,
  input  logic signed [nb-1:0] DI,
  output logic signed [nb-1:0] DOR,
  output logic signed [nb-1:0] DOI,
  output logic                 RDY,
  output logic                 VLD
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [1:0] state;
  logic [5:0] wc;
  logic       bs;
  logic       restart;
  logic       active;
  logic       wr_en;
  logic       rd_en;
  logic [5:0] wa;
  logic [5:0] ra;
  logic       vld_p0;
  logic       rdy_p0;
  logic       sel_p0;

  function automatic logic [5:0] bitrev6(input logic [5:0] a);
    return {a[0], a[1], a[2], a[3], a[4], a[5]};
  endfunction

  // A START from idle or mid-frame forces the current write index to 0.
  // A START on a natural boundary (wc==0) is just an ordinary boundary.
  always_comb begin
    restart = ED && START && ((state == IDLE) || (wc != 6'd0));
    active  = (state != IDLE) || restart;
    wr_en   = ED && active;
    rd_en   = ED && (state == STREAM) && !restart;
    wa      = restart ? 6'd0 : wc;
    ra      = bitrev6(wa);
  end

  // Write index, bank select and frame-phase state machine
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      wc    <= 6'd0;
      bs    <= 1'b0;
    end else if (wr_en) begin
      wc <= wa + 6'd1;
      if (restart) begin
        state <= FILL;
      end else if (wa == 6'd63) begin
        bs    <= ~bs;
        state <= STREAM;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic signed [nb-1:0] mem_r [64];
    logic signed [nb-1:0] mem_i [64];
    logic signed [nb-1:0] q_r;
    logic signed [nb-1:0] q_i;
    logic                 we;
    logic                 en;
    logic [5:0]           addr;

    assign we   = wr_en && (bs == 1'(b));
    assign en   = we || (rd_en && (bs != 1'(b)));
    assign addr = we ? wa : ra;

    // Single-port real/imag RAM pair with registered read data (stage p0)
    always_ff @(posedge CLK) begin
      if (en) begin
        if (we) begin
          mem_r[addr] <= DR;
          mem_i[addr] <= DI;
        end
        q_r <= mem_r[addr];
        q_i <= mem_i[addr];
      end
    end
  end

  // Stage p0: track which bank was read and whether the read was a frame read
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_p0 <= 1'b0;
      rdy_p0 <= 1'b0;
      sel_p0 <= 1'b0;
    end else if (ED) begin
      vld_p0 <= rd_en;
      rdy_p0 <= rd_en && (wa == 6'd0);
      sel_p0 <= ~bs;
    end
  end

  // Stage p1: output register; RDY is cleared on a disabled cycle so it never stretches
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DOR <= '0;
      DOI <= '0;
      VLD <= 1'b0;
      RDY <= 1'b0;
    end else begin
      RDY <= ED && rdy_p0;
      if (ED) begin
        VLD <= vld_p0;
        DOR <= sel_p0 ? g_bank[1].q_r : g_bank[0].q_r;
        DOI <= sel_p0 ? g_bank[1].q_i : g_bank[0].q_i;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Bench for fft_bitrev_buf: each scenario logs its enabled-cycle inputs, derives the
// expected output stream from a frame-level reorder model and compares per cycle.
module tb_fft_bitrev_buf;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                ED = 1'b0;
  logic                START = 1'b0;
  logic signed [15:0]  DR = '0;
  logic signed [15:0]  DI = '0;
  logic signed [15:0]  DOR;
  logic signed [15:0]  DOI;
  logic                RDY;
  logic                VLD;

  int errors = 0;
  int checks = 0;

  int nclk;
  int necyc;
  logic               r_ed   [2048];
  logic               r_vld  [2048];
  logic               r_rdy  [2048];
  logic signed [15:0] r_dor  [2048];
  logic signed [15:0] r_doi  [2048];
  int                 r_ecyc [2048];
  logic               i_start[1024];
  logic signed [15:0] i_dr   [1024];
  logic signed [15:0] i_di   [1024];
  logic               e_vld  [1200];
  logic               e_rdy  [1200];
  logic signed [15:0] e_dr   [1200];
  logic signed [15:0] e_di   [1200];

  fft_bitrev_buf #(.nb(16)) dut (
    .CLK(CLK), .RST(RST), .ED(ED), .START(START), .DR(DR), .DI(DI),
    .DOR(DOR), .DOI(DOI), .RDY(RDY), .VLD(VLD)
  );

  always #5 CLK = ~CLK;

  function automatic int rev(input int j);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if ((j >> b) & 1) r = r + (1 << (5 - b));
    return r;
  endfunction

  function automatic logic signed [15:0] rnd();
    return 16'($urandom);
  endfunction

  task automatic begin_run();
    @(negedge CLK);
    RST = 1'b0; ED = 1'b0; START = 1'b0; DR = '0; DI = '0;
    @(negedge CLK);
    RST = 1'b1;
    nclk = 0;
    necyc = 0;
  endtask

  task automatic drive(input logic ed, input logic st, input logic signed [15:0] dr,
                       input logic signed [15:0] di);
    ED = ed; START = st; DR = dr; DI = di;
    @(posedge CLK);
    if (ed) begin
      i_start[necyc] = st; i_dr[necyc] = dr; i_di[necyc] = di;
      necyc++;
    end
    #1;
    r_ed[nclk] = ed; r_ecyc[nclk] = necyc; r_vld[nclk] = VLD; r_rdy[nclk] = RDY;
    r_dor[nclk] = DOR; r_doi[nclk] = DOI;
    nclk++;
  endtask

  // Frame-level reference: a frame starts on START (from idle or mid-frame), each
  // complete 64-sample frame appears 66 enabled cycles after its first sample,
  // output j carrying sample rev(j).
  task automatic build_model();
    logic signed [15:0] fr [64];
    logic signed [15:0] fi [64];
    bit idle;
    int k;
    int v;
    idle = 1; k = 0;
    for (int c = 0; c <= necyc; c++) begin
      e_vld[c] = 0; e_rdy[c] = 0; e_dr[c] = '0; e_di[c] = '0;
    end
    for (int c = 0; c < necyc; c++) begin
      if (i_start[c] && (idle || k != 0)) begin
        idle = 0; k = 0;
      end
      if (!idle) begin
        fr[k] = i_dr[c]; fi[k] = i_di[c];
        if (k == 63) begin
          for (int j = 0; j < 64; j++) begin
            v = c - 63 + 66 + j;
            if (v <= necyc) begin
              e_vld[v] = 1; e_rdy[v] = (j == 0); e_dr[v] = fr[rev(j)]; e_di[v] = fi[rev(j)];
            end
          end
        end
        k = (k + 1) % 64;
      end
    end
  endtask

  task automatic test_reset();
    int c;
    begin_run();
    checks++;
    if (DOR !== 16'sd0 || DOI !== 16'sd0 || RDY !== 1'b0 || VLD !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got dor=%0d doi=%0d rdy=%b vld=%b required all 0", DOR, DOI, RDY, VLD);
    end
    for (int k = 0; k < 64; k++) drive(1'b1, k == 0, 16'(k), 16'(-k));
    for (int k = 0; k < 80; k++) drive(1'b1, 1'b0, rnd(), rnd());
    checks++;
    if (VLD !== 1'b1) begin
      errors++;
      $display("FAIL reset_prestream got vld=%b required 1", VLD);
    end
    #3 RST = 1'b0;
    #1;
    checks++;
    if (DOR !== 16'sd0 || DOI !== 16'sd0 || RDY !== 1'b0 || VLD !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got dor=%0d doi=%0d rdy=%b vld=%b required all 0", DOR, DOI, RDY, VLD);
    end
    begin_run();
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, rnd(), rnd());
    for (int k = 0; k < 64; k++) drive(1'b1, k == 0, rnd(), rnd());
    for (int k = 0; k < 140; k++) drive(1'b1, 1'b0, rnd(), rnd());
    build_model();
    for (int n = 0; n < nclk; n++) begin
      c = r_ecyc[n];
      checks++;
      if (r_vld[n] !== e_vld[c] || r_rdy[n] !== e_rdy[c] ||
          (e_vld[c] && (r_dor[n] !== e_dr[c] || r_doi[n] !== e_di[c]))) begin
        errors++;
        $display("FAIL reset_restream cyc=%0d got vld=%b rdy=%b dr=%0d di=%0d required vld=%b rdy=%b dr=%0d di=%0d",
                 c, r_vld[n], r_rdy[n], r_dor[n], r_doi[n], e_vld[c], e_rdy[c], e_dr[c], e_di[c]);
      end
    end
  endtask

  task automatic test_single();
    int c;
    int nv;
    int nr;
    int rpos;
    begin_run();
    for (int k = 0; k < 64; k++) drive(1'b1, k == 0, 16'(k), 16'(-k));
    for (int k = 0; k < 65; k++) drive(1'b1, 1'b0, 16'sd0, 16'sd0);
    build_model();
    nv = 0; nr = 0; rpos = -1;
    for (int n = 0; n < nclk; n++) begin
      c = r_ecyc[n];
      if (r_vld[n]) nv++;
      if (r_rdy[n]) begin nr++; rpos = c; end
      checks++;
      if (r_vld[n] !== e_vld[c] || r_rdy[n] !== e_rdy[c] ||
          (e_vld[c] && (r_dor[n] !== e_dr[c] || r_doi[n] !== e_di[c]))) begin
        errors++;
        $display("FAIL single_frame cyc=%0d got vld=%b rdy=%b dr=%0d di=%0d required vld=%b rdy=%b dr=%0d di=%0d",
                 c, r_vld[n], r_rdy[n], r_dor[n], r_doi[n], e_vld[c], e_rdy[c], e_dr[c], e_di[c]);
      end
    end
    checks++;
    if (nv != 64) begin
      errors++;
      $display("FAIL single_vld_len got %0d required 64", nv);
    end
    checks++;
    if (nr != 1 || rpos != 66) begin
      errors++;
      $display("FAIL single_rdy got count=%0d at=%0d required count=1 at=66", nr, rpos);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int rq[$];
    for (int pass = 0; pass < 2; pass++) begin
      begin_run();
      for (int f = 0; f < 3; f++)
        for (int k = 0; k < 64; k++)
          drive(1'b1, (k == 0) && (f == 0 || pass == 1), 16'(f * 64 + k), 16'(-(f * 64 + k) - 7));
      for (int k = 0; k < 66; k++) drive(1'b1, 1'b0, 16'sd0, 16'sd0);
      build_model();
      rq.delete();
      for (int n = 0; n < nclk; n++) begin
        c = r_ecyc[n];
        if (r_rdy[n]) rq.push_back(c);
        checks++;
        if (r_vld[n] !== e_vld[c] || r_rdy[n] !== e_rdy[c] ||
            (e_vld[c] && (r_dor[n] !== e_dr[c] || r_doi[n] !== e_di[c]))) begin
          errors++;
          $display("FAIL b2b_pass%0d cyc=%0d got vld=%b rdy=%b dr=%0d di=%0d required vld=%b rdy=%b dr=%0d di=%0d",
                   pass, c, r_vld[n], r_rdy[n], r_dor[n], r_doi[n], e_vld[c], e_rdy[c], e_dr[c], e_di[c]);
        end
      end
      checks++;
      if (rq.size() < 3 || rq[0] != 66 || rq[1] != 130 || rq[2] != 194) begin
        errors++;
        $display("FAIL b2b_rdy_pass%0d got %0d pulses first=%0d required pulses at 66,130,194",
                 pass, rq.size(), (rq.size() > 0) ? rq[0] : -1);
      end
    end
  endtask

  task automatic test_ed_gating();
    int c;
    int guard;
    begin_run();
    for (int k = 0; k < 128 + 140; k++) begin
      guard = 0;
      while ($urandom_range(99) < 30 && guard < 20) begin
        drive(1'b0, ($urandom_range(1) == 1), rnd(), rnd());
        guard++;
      end
      drive(1'b1, k == 0, rnd(), rnd());
    end
    build_model();
    for (int n = 0; n < nclk; n++) begin
      c = r_ecyc[n];
      if (r_ed[n]) begin
        checks++;
        if (r_vld[n] !== e_vld[c] || r_rdy[n] !== e_rdy[c] ||
            (e_vld[c] && (r_dor[n] !== e_dr[c] || r_doi[n] !== e_di[c]))) begin
          errors++;
          $display("FAIL gating_stream cyc=%0d got vld=%b rdy=%b dr=%0d di=%0d required vld=%b rdy=%b dr=%0d di=%0d",
                   c, r_vld[n], r_rdy[n], r_dor[n], r_doi[n], e_vld[c], e_rdy[c], e_dr[c], e_di[c]);
        end
      end else if (n > 0) begin
        checks++;
        if (r_rdy[n] !== 1'b0 || r_vld[n] !== r_vld[n-1] || r_dor[n] !== r_dor[n-1] ||
            r_doi[n] !== r_doi[n-1]) begin
          errors++;
          $display("FAIL gating_hold clk=%0d got vld=%b rdy=%b dr=%0d di=%0d required rdy=0 vld=%b dr=%0d di=%0d",
                   n, r_vld[n], r_rdy[n], r_dor[n], r_doi[n], r_vld[n-1], r_dor[n-1], r_doi[n-1]);
        end
      end
    end
  endtask

  task automatic test_restart();
    int c;
    int nr;
    int rpos;
    begin_run();
    for (int k = 0; k < 20; k++) drive(1'b1, k == 0, rnd(), rnd());
    for (int k = 0; k < 64; k++) drive(1'b1, k == 0, 16'(100 + k), 16'(-100 - k));
    for (int k = 0; k < 140; k++) drive(1'b1, 1'b0, rnd(), rnd());
    build_model();
    nr = 0; rpos = -1;
    for (int n = 0; n < nclk; n++) begin
      c = r_ecyc[n];
      if (r_rdy[n] && rpos < 0) rpos = c;
      if (r_rdy[n]) nr++;
      checks++;
      if (r_vld[n] !== e_vld[c] || r_rdy[n] !== e_rdy[c] ||
          (e_vld[c] && (r_dor[n] !== e_dr[c] || r_doi[n] !== e_di[c]))) begin
        errors++;
        $display("FAIL restart cyc=%0d got vld=%b rdy=%b dr=%0d di=%0d required vld=%b rdy=%b dr=%0d di=%0d",
                 c, r_vld[n], r_rdy[n], r_dor[n], r_doi[n], e_vld[c], e_rdy[c], e_dr[c], e_di[c]);
      end
    end
    checks++;
    if (rpos != 86) begin
      errors++;
      $display("FAIL restart_rdy got first rdy at %0d required 86", rpos);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ed_gating();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
